vga_apb_initiator: RTL

APB requester that feeds the VGA APB responder. It buffers 24-bit pixels in a small FIFO and accepts single-bit control requests, then issues single APB write transfers for each. Control writes go to the control register and pixel writes go to the data address. It sits between the pixel/frame source and the VGA APB slave port, with timeout and error accounting.

---
 rtl/vga_apb_initiator_if.sv | 23 ++
 rtl/vga_apb_initiator.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vga_apb_initiator_if.sv
// APB bus bundle between the VGA pixel initiator (master) and the VGA APB responder (slave).
interface vga_apb_initiator_if;
  logic [31:0] out_paddr;
  logic        out_psel;
  logic        out_penable;
  logic [2:0]  out_pprot;
  logic        out_pwrite;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic        out_pready;
  logic [31:0] out_prdata;
  logic        out_pslverr;

  modport master (
    output out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb,
    input  out_pready, out_prdata, out_pslverr
  );

  modport slave (
    input  out_paddr, out_psel, out_penable, out_pprot, out_pwrite, out_pwdata, out_pstrb,
    output out_pready, out_prdata, out_pslverr
  );
endinterface

// File: rtl/vga_apb_initiator.sv
// APB write initiator: queues 24-bit pixels and one pending control bit, then issues
// single APB writes to the VGA responder with timeout and error accounting.
module vga_apb_initiator #(
  parameter logic [31:0] DATA_ADDR  = 32'h2100_0000,
  parameter logic [31:0] CTRL_ADDR  = 32'h2100_0010,
  parameter int          FIFO_DEPTH = 4,
  parameter int          TIMEOUT    = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pix_valid,
  output logic                pix_ready,
  input  logic [23:0]         pix_data,
  input  logic                ctrl_valid,
  output logic                ctrl_ready,
  input  logic                ctrl_data,
  vga_apb_initiator_if.master apb,
  output logic                busy,
  output logic [7:0]          err_count,
  output logic                timeout_err
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] WCNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [23:0]   fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ctrl_pend_q, ctrl_pend_d;
  logic          ctrl_val_q, ctrl_val_d;
  logic [31:0]   paddr_q, paddr_d;
  logic [31:0]   pwdata_q, pwdata_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [7:0]    err_q, err_d;
  logic          tmo_q, tmo_d;

  logic fifo_empty, fifo_full, push, pop, ctrl_acc, work, load;
  logic unused_prdata;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == DEPTH_C);
  assign pix_ready  = !fifo_full && !reset;
  assign ctrl_ready = !ctrl_pend_q && !reset;
  assign push       = pix_valid && pix_ready;
  assign ctrl_acc   = ctrl_valid && ctrl_ready;
  assign work       = ctrl_pend_q || !fifo_empty;

  // A timeout is an abort: it always returns to IDLE so psel drops for a cycle.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (work) begin
          state_d = S_SETUP;
          load    = 1'b1;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        wcnt_d  = WCNT_ONE;
      end
      S_ACCESS: begin
        if (apb.out_pready) begin
          if (apb.out_pslverr) err_d = sat_inc8(err_q);
          if (work) begin
            state_d = S_SETUP;
            load    = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (wcnt_q == TIMEOUT_C) begin
          err_d   = sat_inc8(err_q);
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wcnt_d = wcnt_q + WCNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Transfer selection on SETUP entry; a pending control write beats queued pixels.
  always_comb begin
    pop         = 1'b0;
    ctrl_pend_d = ctrl_pend_q;
    ctrl_val_d  = ctrl_val_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    if (load) begin
      if (ctrl_pend_q) begin
        paddr_d     = CTRL_ADDR;
        pwdata_d    = {31'b0, ctrl_val_q};
        ctrl_pend_d = 1'b0;
      end else begin
        paddr_d  = DATA_ADDR;
        pwdata_d = {8'h00, fifo_mem_q[rptr_q]};
        pop      = 1'b1;
      end
    end
    if (ctrl_acc) begin
      ctrl_pend_d = 1'b1;
      ctrl_val_d  = ctrl_data;
    end
    wptr_d = push ? wptr_q + PTR_ONE : wptr_q;
    rptr_d = pop  ? rptr_q + PTR_ONE : rptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      ctrl_pend_q <= 1'b0;
      ctrl_val_q  <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      wcnt_q      <= '0;
      err_q       <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      ctrl_pend_q <= ctrl_pend_d;
      ctrl_val_q  <= ctrl_val_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      wcnt_q      <= wcnt_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem_q[wptr_q] <= pix_data;
  end

  assign apb.out_psel    = (state_q != S_IDLE);
  assign apb.out_penable = (state_q == S_ACCESS);
  assign apb.out_pwrite  = (state_q != S_IDLE);
  assign apb.out_pstrb   = (state_q != S_IDLE) ? 4'hF : 4'h0;
  assign apb.out_pprot   = 3'b000;
  assign apb.out_paddr   = paddr_q;
  assign apb.out_pwdata  = pwdata_q;

  assign busy        = (state_q != S_IDLE) || !fifo_empty || ctrl_pend_q;
  assign err_count   = err_q;
  assign timeout_err = tmo_q;

  assign unused_prdata = ^apb.out_prdata;
endmodule
